flick_scheduler: RTL and testbench

//  Shares one bound_flasher instance between N_REQ requesters (buttons/host agents).

---
 rtl/flick_scheduler_pkg.sv | 20 ++
 rtl/flick_scheduler_rr_pick.sv | 31 +++
 rtl/flick_scheduler.sv | 129 ++++++++++++
 tb/tb_flick_scheduler.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/flick_scheduler_pkg.sv
// Shared types and sizing helpers for the flick scheduler.
// No logic; widths and state encoding only.
package flick_scheduler_pkg;

    localparam int unsigned LED_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLICK,
        ST_WAIT_START,
        ST_WAIT_IDLE,
        ST_DONE
    } state_t;

    // Counter width that stays at least one bit wide for tiny parameter values.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/flick_scheduler_rr_pick.sv
// Round-robin picker: the first requester at or after i_ptr, wrapping, wins.
// Purely combinational; no state, no backpressure.
module flick_scheduler_rr_pick
    import flick_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PW    = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [PW-1:0]    o_idx,
    output logic             o_vld
);

    int unsigned v_idx;

    // Walk from the farthest offset down so the nearest hit is written last.
    always_comb begin
        o_vld = 1'b0;
        o_idx = '0;
        v_idx = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            v_idx = (int'(i_ptr) + k) % N_REQ;
            if (i_req[v_idx[PW-1:0]]) begin
                o_vld = 1'b1;
                o_idx = v_idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/flick_scheduler.sv
// Grants one requester at a time to the shared flasher, pulses flick, tracks the run to idle.
// Latency: req -> gnt/flick one edge; requesters wait (no grant) while the flasher is busy.
module flick_scheduler
    import flick_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned LED_W        = LED_W_DEF,
    parameter int unsigned FLICK_CYCLES = 3,
    parameter int unsigned TIMEOUT      = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic [LED_W-1:0] i_led_state,
    output logic [N_REQ-1:0] o_gnt,
    output logic [N_REQ-1:0] o_done,
    output logic             o_flick,
    output logic             o_busy,
    output logic             o_timeout_err
);

    localparam int unsigned PW = clog2_min1(N_REQ);
    localparam int unsigned FW = clog2_min1(FLICK_CYCLES + 1);
    localparam int unsigned TW = clog2_min1(TIMEOUT);

    state_t          r_state, w_nxt_state;
    logic [FW-1:0]   r_fcnt, w_nxt_fcnt;
    logic [TW-1:0]   r_tcnt, w_nxt_tcnt, w_tcnt_inc;
    logic [PW-1:0]   r_rr_ptr, w_nxt_rr_ptr;
    logic [PW-1:0]   r_winner, w_nxt_winner;
    logic            r_to_flag, w_nxt_to_flag;
    logic [PW-1:0]   w_pick_idx;
    logic            w_pick_vld;
    logic            w_led_idle;
    logic [N_REQ-1:0] w_one;

    flick_scheduler_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .i_req (i_req),
        .i_ptr (r_rr_ptr),
        .o_idx (w_pick_idx),
        .o_vld (w_pick_vld)
    );

    assign w_led_idle = (i_led_state == '0);
    assign w_tcnt_inc = (r_tcnt == '1) ? r_tcnt : r_tcnt + 1'b1;

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_fcnt    = r_fcnt;
        w_nxt_tcnt    = r_tcnt;
        w_nxt_rr_ptr  = r_rr_ptr;
        w_nxt_winner  = r_winner;
        w_nxt_to_flag = r_to_flag;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld && w_led_idle) begin
                    w_nxt_state   = ST_FLICK;
                    w_nxt_winner  = w_pick_idx;
                    w_nxt_fcnt    = FW'(1);
                    w_nxt_to_flag = 1'b0;
                end
            end
            ST_FLICK: begin
                if (r_fcnt >= FW'(FLICK_CYCLES)) begin
                    w_nxt_state = ST_WAIT_START;
                    w_nxt_tcnt  = '0;
                end else begin
                    w_nxt_fcnt = r_fcnt + 1'b1;
                end
            end
            ST_WAIT_START: begin
                if (!w_led_idle) begin
                    w_nxt_state = ST_WAIT_IDLE;
                    w_nxt_tcnt  = '0;
                end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                    w_nxt_state   = ST_DONE;
                    w_nxt_to_flag = 1'b1;
                end else begin
                    w_nxt_tcnt = w_tcnt_inc;
                end
            end
            ST_WAIT_IDLE: begin
                if (w_led_idle) begin
                    w_nxt_state = ST_DONE;
                end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                    w_nxt_state   = ST_DONE;
                    w_nxt_to_flag = 1'b1;
                end else begin
                    w_nxt_tcnt = w_tcnt_inc;
                end
            end
            ST_DONE: begin
                w_nxt_state  = ST_IDLE;
                w_nxt_rr_ptr = (r_winner == PW'(N_REQ - 1)) ? '0 : r_winner + 1'b1;
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_fcnt    <= '0;
            r_tcnt    <= '0;
            r_rr_ptr  <= '0;
            r_winner  <= '0;
            r_to_flag <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_fcnt    <= w_nxt_fcnt;
            r_tcnt    <= w_nxt_tcnt;
            r_rr_ptr  <= w_nxt_rr_ptr;
            r_winner  <= w_nxt_winner;
            r_to_flag <= w_nxt_to_flag;
        end
    end

    // Outputs decode straight from registered state, so flick/done can never outlive their state.
    assign w_one         = {{(N_REQ-1){1'b0}}, 1'b1};
    assign o_busy        = (r_state != ST_IDLE);
    assign o_gnt         = o_busy ? (w_one << r_winner) : '0;
    assign o_done        = (r_state == ST_DONE) ? (w_one << r_winner) : '0;
    assign o_flick       = (r_state == ST_FLICK);
    assign o_timeout_err = (r_state == ST_DONE) && r_to_flag;

endmodule

// File: tb/tb_flick_scheduler.sv
// Directed bench for flick_scheduler; the bench plays the flasher by driving led_state.
module tb_flick_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] led;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        flick;
    logic        busy;
    logic        terr;

    int n_chk = 0;
    int n_err = 0;

    always #1 clk = ~clk;

    flick_scheduler dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_led_state   (led),
        .o_gnt         (gnt),
        .o_done        (done),
        .o_flick       (flick),
        .o_busy        (busy),
        .o_timeout_err (terr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant(input int k, input string tag);
        int n;
        n = 0;
        while (gnt == 4'b0 && n < 8) begin
            tick(1);
            n++;
        end
        chk({tag, "_gnt"}, 32'(gnt), 32'(1 << k));
        chk({tag, "_flick_on"}, 32'(flick), 32'd1);
    endtask

    task automatic run_flick(input string tag);
        int cnt;
        cnt = 0;
        while (flick && cnt < 10) begin
            cnt++;
            tick(1);
        end
        chk({tag, "_flick_len"}, 32'(cnt), 32'd3);
    endtask

    task automatic finish_ok(input int k, input int run, input string tag);
        int n;
        led = 16'h8000;
        tick(run);
        chk({tag, "_gnt_held"}, 32'(gnt), 32'(1 << k));
        chk({tag, "_no_early_done"}, 32'(done), 32'd0);
        led = 16'h0;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (done == 4'b0 && n < 20);
        chk({tag, "_done_lat"}, 32'(n), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'(1 << k));
        chk({tag, "_terr"}, 32'(terr), 32'd0);
        tick(1);
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'({busy, gnt}), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        req = 4'b0;
        led = 16'h0;
        tick(3);
        chk("rst_outs", 32'({gnt, done, flick, busy, terr}), 32'd0);
        rst = 1'b0;
        tick(1);

        // single requester: one-edge grant latency, rr_ptr moves to 2
        req = 4'b0010;
        tick(1);
        chk("t2_gnt_lat", 32'(gnt), 32'h2);
        chk("t2_busy", 32'(busy), 32'd1);
        req = 4'b0000;
        run_flick("t2");
        finish_ok(1, 4, "t2");

        // pointer at 2 wraps to requester 0; reset lands mid-WAIT_IDLE
        req = 4'b0001;
        wait_grant(0, "t1");
        req = 4'b0000;
        run_flick("t1");
        led = 16'h00f0;
        tick(2);
        rst = 1'b1;
        led = 16'h0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("t1_rst_outs", 32'({gnt, done, flick, busy, terr}), 32'd0);
        end
        rst = 1'b0;
        tick(1);
        chk("t1_post_rst_idle", 32'({gnt, done, busy}), 32'd0);

        // all requesting: reset pointer starts at 0, then strict rotation
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(i % 4, $sformatf("t3_%0d", i));
            if (i == 4) req = 4'b0000;
            run_flick($sformatf("t3_%0d", i));
            finish_ok(i % 4, 2 + i, $sformatf("t3_%0d", i));
        end
        req = 4'b0000;

        // flasher busy from elsewhere blocks the grant
        req = 4'b0001;
        led = 16'h0001;
        tick(5);
        chk("t4_blocked", 32'({gnt, busy, flick}), 32'd0);
        led = 16'h0;
        tick(1);
        chk("t4_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        run_flick("t4");
        finish_ok(0, 3, "t4");

        // flasher never starts: 256 waiting cycles then done+timeout_err
        req = 4'b1000;
        wait_grant(3, "t5");
        req = 4'b0000;
        run_flick("t5");
        n = 0;
        while (done == 4'b0 && n < 400) begin
            tick(1);
            n++;
        end
        chk("t5_to_cycles", 32'(n), 32'd256);
        chk("t5_done", 32'(done), 32'h8);
        chk("t5_terr", 32'(terr), 32'd1);
        tick(1);
        chk("t5_after", 32'({busy, terr, done}), 32'd0);

        // requester 2 withdraws mid-flick; service still completes, then 3 is served
        req = 4'b1100;
        wait_grant(2, "t6a");
        req = 4'b1000;
        run_flick("t6a");
        finish_ok(2, 3, "t6a");
        wait_grant(3, "t6b");
        req = 4'b0000;
        run_flick("t6b");
        finish_ok(3, 2, "t6b");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #40000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
